// File: rtl/dmem_responder.sv
// Data-memory responder for the core's data port: byte-lane RAM, RV32I load/store
// formatting, and an MMIO page holding the test-exit register, console byte and cycle counter.
module dmem_responder #(
    parameter int                  DATA_LEN    = 32,
    parameter int                  DEPTH_WORDS = 4096,
    parameter logic [DATA_LEN-1:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          mem_fn,
    input  logic [DATA_LEN-1:0] addr,
    input  logic [DATA_LEN-1:0] wdata,
    output logic [DATA_LEN-1:0] rdata,
    output logic [DATA_LEN-1:0] tohost,
    output logic                tohost_valid,
    output logic [7:0]          console_data,
    output logic                console_valid,
    output logic                misalign_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LH  = 3'd1;
    localparam logic [2:0] MEM_LW  = 3'd2;
    localparam logic [2:0] MEM_LBU = 3'd3;
    localparam logic [2:0] MEM_LHU = 3'd4;
    localparam logic [2:0] MEM_SB  = 3'd5;
    localparam logic [2:0] MEM_SH  = 3'd6;
    localparam logic [2:0] MEM_SW  = 3'd7;

    localparam logic [15:0] OFF_TOHOST   = 16'h0000;
    localparam logic [15:0] OFF_CONSOLE  = 16'h0004;
    localparam logic [15:0] OFF_CYCLE_LO = 16'h0008;
    localparam logic [15:0] OFF_CYCLE_HI = 16'h000C;

    logic [7:0] mem_q [DEPTH_WORDS][4];

    logic [DATA_LEN-1:0] tohost_q, tohost_d;
    logic                tohost_valid_q, tohost_valid_d;
    logic [7:0]          console_data_q, console_data_d;
    logic                console_valid_q, console_valid_d;
    logic                fault_q, fault_d;
    logic [63:0]         cycle_q, cycle_d;

    logic                is_store;
    logic                misaligned;
    logic                in_ram;
    logic                in_mmio;
    logic [AW-1:0]       word_idx;
    logic [15:0]         mmio_off;
    logic [31:0]         ram_word;
    logic [31:0]         mmio_word;
    logic [31:0]         src_word;
    logic [7:0]          sel_byte;
    logic [15:0]         sel_half;
    logic [31:0]         load_word;
    logic [3:0]          lane_mask;
    logic [3:0]          ram_we;
    logic [31:0]         lane_wdata;
    logic                wr_ok;

    assign word_idx = addr[AW+1:2];
    assign in_ram   = (addr[DATA_LEN-1:AW+2] == '0);
    assign in_mmio  = (addr[DATA_LEN-1:16] == MMIO_BASE[DATA_LEN-1:16]);
    assign mmio_off = addr[15:0];
    assign is_store = (mem_fn == MEM_SB) || (mem_fn == MEM_SH) || (mem_fn == MEM_SW);

    always_comb begin
        misaligned = 1'b0;
        case (mem_fn)
            MEM_LH, MEM_LHU, MEM_SH: misaligned = addr[0];
            MEM_LW, MEM_SW:          misaligned = |addr[1:0];
            default:                 misaligned = 1'b0;
        endcase
    end

    assign ram_word = {mem_q[word_idx][3], mem_q[word_idx][2],
                       mem_q[word_idx][1], mem_q[word_idx][0]};

    always_comb begin
        mmio_word = '0;
        case (mmio_off)
            OFF_TOHOST:   mmio_word = tohost_q;
            OFF_CONSOLE:  mmio_word = {24'b0, console_data_q};
            OFF_CYCLE_LO: mmio_word = cycle_q[31:0];
            OFF_CYCLE_HI: mmio_word = cycle_q[63:32];
            default:      mmio_word = '0;
        endcase
    end

    // Load path reads only current state, so a same-cycle store never shows up here.
    always_comb begin
        src_word  = in_ram ? ram_word : (in_mmio ? mmio_word : 32'b0);
        sel_byte  = src_word[8*addr[1:0] +: 8];
        sel_half  = addr[1] ? src_word[31:16] : src_word[15:0];
        load_word = '0;
        if (!misaligned) begin
            case (mem_fn)
                MEM_LB:  load_word = {{24{sel_byte[7]}}, sel_byte};
                MEM_LBU: load_word = {24'b0, sel_byte};
                MEM_LH:  load_word = {{16{sel_half[15]}}, sel_half};
                MEM_LHU: load_word = {16'b0, sel_half};
                MEM_LW:  load_word = src_word;
                default: load_word = '0;
            endcase
        end
    end

    assign rdata = load_word;

    // reset is folded in here because the RAM itself has no reset.
    always_comb begin
        wr_ok      = is_store && !misaligned && reset;
        lane_mask  = 4'b0000;
        lane_wdata = wdata;
        case (mem_fn)
            MEM_SB: begin
                lane_mask  = 4'b0001 << addr[1:0];
                lane_wdata = {4{wdata[7:0]}};
            end
            MEM_SH: begin
                lane_mask  = addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
            end
            MEM_SW: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
        ram_we = (wr_ok && in_ram) ? lane_mask : 4'b0000;
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (ram_we[l]) begin
                mem_q[word_idx][l] <= lane_wdata[8*l +: 8];
            end
        end
    end

    always_comb begin
        tohost_d        = tohost_q;
        tohost_valid_d  = tohost_valid_q;
        console_data_d  = console_data_q;
        console_valid_d = 1'b0;
        fault_d         = fault_q | misaligned;
        cycle_d         = cycle_q + 64'd1;
        if (is_store && !misaligned && in_mmio) begin
            if (mmio_off == OFF_TOHOST && mem_fn == MEM_SW) begin
                tohost_d       = wdata;
                tohost_valid_d = 1'b1;
            end
            if (mmio_off == OFF_CONSOLE && (mem_fn == MEM_SB || mem_fn == MEM_SW)) begin
                console_data_d  = wdata[7:0];
                console_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tohost_q        <= '0;
            tohost_valid_q  <= 1'b0;
            console_data_q  <= '0;
            console_valid_q <= 1'b0;
            fault_q         <= 1'b0;
            cycle_q         <= '0;
        end else begin
            tohost_q        <= tohost_d;
            tohost_valid_q  <= tohost_valid_d;
            console_data_q  <= console_data_d;
            console_valid_q <= console_valid_d;
            fault_q         <= fault_d;
            cycle_q         <= cycle_d;
        end
    end

    assign tohost         = tohost_q;
    assign tohost_valid   = tohost_valid_q;
    assign console_data   = console_data_q;
    assign console_valid  = console_valid_q;
    assign misalign_fault = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand sequences for fault/reset,
// and random traffic checked against a byte-array reference model.
module tb_dmem_responder;

    localparam int DW = 4096;
    localparam int RB = DW * 4;
    localparam logic [31:0] MB = 32'hFFFF_0000;

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                           LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  mem_fn;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, tohost;
    logic        tohost_valid, console_valid, misalign_fault;
    logic [7:0]  console_data;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk(clk), .reset(reset), .mem_fn(mem_fn), .addr(addr), .wdata(wdata),
        .rdata(rdata), .tohost(tohost), .tohost_valid(tohost_valid),
        .console_data(console_data), .console_valid(console_valid),
        .misalign_fault(misalign_fault)
    );

    int checks = 0;
    int errors = 0;

    byte unsigned    m_mem [RB];
    logic [31:0]     m_tohost;
    bit              m_tv, m_cv, m_fault;
    logic [7:0]      m_con;
    longint unsigned m_cyc;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int fsize(input logic [2:0] fn);
        if (fn == LB || fn == LBU || fn == SB) return 1;
        if (fn == LH || fn == LHU || fn == SH) return 2;
        return 4;
    endfunction

    function automatic bit fstore(input logic [2:0] fn);
        return fn == SB || fn == SH || fn == SW;
    endfunction

    function automatic bit is_mis(input logic [2:0] fn, input logic [31:0] a);
        return (int'(a[1:0]) % fsize(fn)) != 0;
    endfunction

    function automatic bit is_ram(input logic [31:0] a);
        return a < 32'(RB);
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return a[31:16] == MB[31:16];
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] fn, input logic [31:0] a);
        logic [31:0] raw;
        int n;
        n = fsize(fn);
        if (fstore(fn) || is_mis(fn, a)) return 32'h0;
        raw = 32'h0;
        if (is_ram(a)) begin
            for (int i = 0; i < n; i++) raw = raw | (32'(m_mem[int'(a) + i]) << (8 * i));
        end else if (is_mmio(a)) begin
            case (a[15:0])
                16'h0:   raw = m_tohost;
                16'h4:   raw = {24'h0, m_con};
                16'h8:   raw = m_cyc[31:0];
                16'hC:   raw = m_cyc[63:32];
                default: raw = 32'h0;
            endcase
            if (n == 1) raw = raw & 32'hFF;
            if (n == 2) raw = raw & 32'hFFFF;
        end
        case (fn)
            LB:      return {{24{raw[7]}}, raw[7:0]};
            LH:      return {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    task automatic m_commit(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = fsize(fn);
        m_cv = 0;
        if (is_mis(fn, a)) begin
            m_fault = 1;
        end else if (fstore(fn)) begin
            if (is_ram(a)) begin
                for (int i = 0; i < n; i++) m_mem[int'(a) + i] = 8'(wd >> (8 * i));
            end else if (is_mmio(a)) begin
                if (a[15:0] == 16'h0 && fn == SW) begin
                    m_tohost = wd;
                    m_tv = 1;
                end
                if (a[15:0] == 16'h4 && (fn == SB || fn == SW)) begin
                    m_con = wd[7:0];
                    m_cv = 1;
                end
            end
        end
        m_cyc++;
    endtask

    task automatic m_reset();
        m_tohost = 0; m_tv = 0; m_con = 0; m_cv = 0; m_fault = 0; m_cyc = 0;
    endtask

    task automatic step(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd,
                        input bit use_exp, input logic [31:0] exp, input string nm);
        mem_fn = fn; addr = a; wdata = wd;
        @(negedge clk);
        check({nm, ".rdata_model"}, rdata, m_load(fn, a));
        if (use_exp) check({nm, ".rdata"}, rdata, exp);
        check({nm, ".tohost"}, tohost, m_tohost);
        check({nm, ".tohost_valid"}, tohost_valid, m_tv);
        check({nm, ".console_data"}, console_data, m_con);
        check({nm, ".console_valid"}, console_valid, m_cv);
        check({nm, ".misalign_fault"}, misalign_fault, m_fault);
        @(posedge clk);
        m_commit(fn, a, wd);
        #1;
    endtask

    typedef struct {
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [21];

    initial begin
        logic [31:0] pre;
        tbl = '{
            '{SW,  32'h10,         32'h8765_4321, 32'h0},
            '{SB,  32'h11,         32'h0000_00AA, 32'h0},
            '{LW,  32'h10,         32'h0,         32'h8765_AA21},
            '{LB,  32'h11,         32'h0,         32'hFFFF_FFAA},
            '{LBU, 32'h11,         32'h0,         32'h0000_00AA},
            '{LH,  32'h12,         32'h0,         32'hFFFF_8765},
            '{LHU, 32'h12,         32'h0,         32'h0000_8765},
            '{SW,  32'h10,         32'h1,         32'h0},
            '{LW,  32'h10,         32'h0,         32'h1},
            '{SB,  MB + 32'h4,     32'h41,        32'h0},
            '{SB,  MB + 32'h4,     32'h41,        32'h0},
            '{LW,  MB + 32'h4,     32'h0,         32'h41},
            '{SW,  MB,             32'h1,         32'h0},
            '{LW,  MB,             32'h0,         32'h1},
            '{SW,  32'h4000_0000,  32'h5,         32'h0},
            '{SW,  MB + 32'h8,     32'hFFFF_FFFF, 32'h0},
            '{LW,  32'h4000_0000,  32'h0,         32'h0},
            '{SW,  32'(RB - 4),    32'h1122_3344, 32'h0},
            '{LW,  32'(RB - 4),    32'h0,         32'h1122_3344},
            '{LW,  32'(RB),        32'h0,         32'h0},
            '{LHU, 32'(RB - 2),    32'h0,         32'h0000_1122}
        };

        mem_fn = LB; addr = 0; wdata = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst.tohost", tohost, 0);
        check("rst.tohost_valid", tohost_valid, 0);
        check("rst.console_data", console_data, 0);
        check("rst.console_valid", console_valid, 0);
        check("rst.misalign_fault", misalign_fault, 0);
        reset = 1'b1;

        step(LW, MB + 32'h8, 0, 1, 32'd0, "cyc_first");
        repeat (3) step(LB, 0, 0, 0, 0, "bubble");
        step(LW, MB + 32'h8, 0, 1, 32'd4, "cyc_fifth");

        for (int w = 0; w < 16; w++) step(SW, 32'(w * 4), $urandom, 0, 0, "fill_lo");
        for (int w = RB - 16; w < RB; w += 4) step(SW, 32'(w), $urandom, 0, 0, "fill_hi");

        for (int i = 0; i < $size(tbl); i++)
            step(tbl[i].fn, tbl[i].a, tbl[i].wd, 1, tbl[i].exp, $sformatf("vec%0d", i));

        // Console pulse held across back-to-back stores.
        step(SB, MB + 32'h4, 32'h41, 0, 0, "con_a");
        step(SB, MB + 32'h4, 32'h42, 0, 0, "con_b");
        check("con.pulse2", console_valid, 1);
        check("con.data2", console_data, 8'h42);
        step(LB, 0, 0, 0, 0, "con_c");
        check("con.pulse_end", console_valid, 0);

        pre = m_load(LW, 32'h20);
        step(SW, 32'h21, 32'hDEAD_BEEF, 1, 32'h0, "mis_sw");
        check("mis.set", misalign_fault, 1);
        step(LW, 32'h20, 0, 1, pre, "mis_unchanged");
        for (int i = 0; i < 10; i++) begin
            step(LW, 32'(4 * i), 0, 0, 0, "mis_hold");
            check("mis.sticky", misalign_fault, 1);
        end

        // Reset asserted mid-cycle with a store pending: store must be lost.
        pre = m_load(LW, 32'h30);
        mem_fn = SW; addr = 32'h30; wdata = 32'hCAFE_F00D;
        #2 reset = 1'b0;
        #1;
        check("rst2.fault_clear", misalign_fault, 0);
        check("rst2.tohost_valid", tohost_valid, 0);
        m_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        step(LW, 32'h30, 0, 1, pre, "rst2.store_lost");
        step(LW, MB + 32'h8, 0, 1, 32'd1, "rst2.cyc");

        for (int i = 0; i < 400; i++) begin
            logic [2:0]  fn;
            logic [31:0] a;
            int          r;
            fn = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 19);
            if (r < 12)      a = 32'($urandom_range(0, 63));
            else if (r < 14) a = 32'(RB - 16 + $urandom_range(0, 15));
            else if (r < 18) a = MB + 32'($urandom_range(0, 19));
            else if (r == 18) a = 32'(RB + $urandom_range(0, 15));
            else             a = 32'h4000_0000 | 32'($urandom_range(0, 255));
            step(fn, a, $urandom, 0, 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
